// File: rtl/pipe_stage_skid.sv
// Pipeline stage latch with valid/ready handshake and a one-entry skid buffer.
//
// Carries NUM_FIELDS packed words of DATA_W bits; field k is in_data[k*DATA_W +: DATA_W].
// in_ready comes straight from a register (no combinational ready path). Empty entries
// always hold zero data, so out_data reads as a nop when out_valid is low.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset, clears all state and counters
//   flush       synchronous kill of both entries; counters keep counting
//   in_valid    upstream presents in_data
//   in_ready    stage can accept (registered)
//   in_data     packed upstream fields
//   out_valid   out_data holds a live item
//   out_ready   downstream accepts this cycle
//   out_data    packed fields to downstream
//   stall_cnt   saturating count of cycles with out_valid=1, out_ready=0
//   bubble_cnt  saturating count of cycles with out_valid=0, out_ready=1
module pipe_stage_skid #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_FIELDS = 6,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W*NUM_FIELDS-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W*NUM_FIELDS-1:0] out_data,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             bubble_cnt
);

  localparam int unsigned W = DATA_W * NUM_FIELDS;

  // State bits are {m_valid, s_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StBusy  = 2'b10,
    StFull  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     m_data_q, m_data_d;
  logic [W-1:0]     s_data_q, s_data_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  logic m_valid, s_valid;
  logic accept, issue;

  assign m_valid    = state_q[1];
  assign s_valid    = state_q[0];
  assign in_ready   = ~s_valid;
  assign out_valid  = m_valid;
  assign out_data   = m_data_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

  assign accept = in_valid & in_ready;
  assign issue  = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;

    if (flush) begin
      state_d  = StEmpty;
      m_data_d = '0;
      s_data_d = '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d  = StBusy;
            m_data_d = in_data;
          end
        end
        StBusy: begin
          if (accept && issue) begin
            m_data_d = in_data;
          end else if (issue) begin
            state_d  = StEmpty;
            m_data_d = '0;
          end else if (accept) begin
            state_d  = StFull;
            s_data_d = in_data;
          end
        end
        StFull: begin
          // in_ready is low here, so only draining is possible.
          if (issue) begin
            state_d  = StBusy;
            m_data_d = s_data_q;
            s_data_d = '0;
          end
        end
        default: begin
          state_d  = StEmpty;
          m_data_d = '0;
          s_data_d = '0;
        end
      endcase
    end
  end

  // Counters use pre-edge out_valid/out_ready and saturate at all-ones.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (!out_valid && out_ready && (bubble_q != '1)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StEmpty;
      m_data_q <= '0;
      s_data_q <= '0;
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, reset and saturation
// sequences, and a random soak against a queue model.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 32;
  localparam int unsigned NF = 6;
  localparam int unsigned W  = DW * NF;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  // Small instance for counter saturation.
  logic        sat_flush, sat_in_valid, sat_in_ready, sat_out_valid, sat_out_ready;
  logic [15:0] sat_in_data, sat_out_data;
  logic [3:0]  sat_stall, sat_bubble;

  pipe_stage_skid #(.DATA_W(DW), .NUM_FIELDS(NF), .CNT_W(CW)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  pipe_stage_skid #(.DATA_W(8), .NUM_FIELDS(2), .CNT_W(4)) u_sat (
    .clk        (clk),
    .reset      (reset),
    .flush      (sat_flush),
    .in_valid   (sat_in_valid),
    .in_ready   (sat_in_ready),
    .in_data    (sat_in_data),
    .out_valid  (sat_out_valid),
    .out_ready  (sat_out_ready),
    .out_data   (sat_out_data),
    .stall_cnt  (sat_stall),
    .bubble_cnt (sat_bubble)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] ir;
    logic        e_ov;
    logic        e_rdy;
    logic [31:0] e_ir;
    int unsigned e_stall;
    int unsigned e_bub;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  logic [W-1:0] q[$];
  int unsigned  m_stall, m_bub;
  logic         r_iv, r_ordy, r_fl;
  logic [W-1:0] r_data, exp_data;

  initial begin
    //             iv ordy fl  ir     ov rdy out    stall bub
    // stream 1..5 at full rate
    vecs[0]  = '{1, 1, 0, 32'h01, 1, 1, 32'h01, 0, 1};
    vecs[1]  = '{1, 1, 0, 32'h02, 1, 1, 32'h02, 0, 1};
    vecs[2]  = '{1, 1, 0, 32'h03, 1, 1, 32'h03, 0, 1};
    vecs[3]  = '{1, 1, 0, 32'h04, 1, 1, 32'h04, 0, 1};
    vecs[4]  = '{1, 1, 0, 32'h05, 1, 1, 32'h05, 0, 1};
    vecs[5]  = '{0, 1, 0, 32'h00, 0, 1, 32'h00, 0, 1};
    vecs[6]  = '{0, 1, 0, 32'h00, 0, 1, 32'h00, 0, 2};
    // backpressure fill, blocked push, then drain
    vecs[7]  = '{1, 0, 0, 32'h11, 1, 1, 32'h11, 0, 2};
    vecs[8]  = '{1, 0, 0, 32'h22, 1, 0, 32'h11, 1, 2};
    vecs[9]  = '{1, 0, 0, 32'h99, 1, 0, 32'h11, 2, 2};
    vecs[10] = '{0, 1, 0, 32'h00, 1, 1, 32'h22, 2, 2};
    vecs[11] = '{0, 1, 0, 32'h00, 0, 1, 32'h00, 2, 2};
    // flush while FULL with an incoming item
    vecs[12] = '{1, 0, 0, 32'h11, 1, 1, 32'h11, 2, 2};
    vecs[13] = '{1, 0, 0, 32'h22, 1, 0, 32'h11, 3, 2};
    vecs[14] = '{1, 0, 1, 32'h33, 0, 1, 32'h00, 4, 2};
    vecs[15] = '{0, 1, 0, 32'h00, 0, 1, 32'h00, 4, 3};
    // flush while BUSY with accept and issue in the same cycle
    vecs[16] = '{1, 1, 0, 32'h44, 1, 1, 32'h44, 4, 4};
    vecs[17] = '{1, 1, 1, 32'h55, 0, 1, 32'h00, 4, 4};
    vecs[18] = '{0, 0, 0, 32'h00, 0, 1, 32'h00, 4, 4};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    sat_flush = 1'b0; sat_in_valid = 1'b0; sat_out_ready = 1'b0; sat_in_data = '0;
    step();
    step();
    reset = 1'b0;
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_out_data", out_data, '0);
    chk("reset_stall", W'(stall_cnt), W'(0));
    chk("reset_bubble", W'(bubble_cnt), W'(0));

    for (int i = 0; i < NV; i++) begin
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      in_data   = W'(vecs[i].ir);
      step();
      chk($sformatf("v%0d_out_valid", i), W'(out_valid), W'(vecs[i].e_ov));
      chk($sformatf("v%0d_in_ready", i), W'(in_ready), W'(vecs[i].e_rdy));
      chk($sformatf("v%0d_out_data", i), out_data, W'(vecs[i].e_ir));
      chk($sformatf("v%0d_stall", i), W'(stall_cnt), W'(vecs[i].e_stall));
      chk($sformatf("v%0d_bubble", i), W'(bubble_cnt), W'(vecs[i].e_bub));
    end
    flush = 1'b0;

    // Reset mid-operation: build FULL with stall_cnt=7.
    in_valid = 1'b1; in_data = W'(32'hA1); out_ready = 1'b0;
    step();
    in_data = W'(32'hB2);
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("pre_reset_stall", W'(stall_cnt), W'(7));
    chk("pre_reset_in_ready", W'(in_ready), W'(0));
    chk("pre_reset_out_data", out_data, W'(32'hA1));
    reset = 1'b1; in_valid = 1'b1; in_data = W'(32'hC3);
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("midreset_out_valid", W'(out_valid), W'(0));
    chk("midreset_in_ready", W'(in_ready), W'(1));
    chk("midreset_out_data", out_data, '0);
    chk("midreset_stall", W'(stall_cnt), W'(0));
    chk("midreset_bubble", W'(bubble_cnt), W'(0));

    // Saturation with CNT_W=4.
    sat_in_valid = 1'b1; sat_in_data = 16'h00AB; sat_out_ready = 1'b0;
    step();
    sat_in_valid = 1'b0;
    chk("sat_out_data", W'(sat_out_data), W'(16'h00AB));
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("sat_stall_%0d", i), W'(sat_stall), W'((i + 1 > 15) ? 15 : i + 1));
    end
    chk("sat_bubble", W'(sat_bubble), W'(0));
    chk("sat_out_valid", W'(sat_out_valid), W'(1));

    // Random soak against a queue model; main DUT is EMPTY with zero counters here.
    m_stall = 0;
    m_bub   = 0;
    for (int c = 0; c < 10000; c++) begin
      r_iv   = ($urandom_range(0, 3) != 0);
      r_ordy = ($urandom_range(0, 1) != 0);
      r_fl   = ($urandom_range(0, 31) == 0);
      for (int k = 0; k < NF; k++) r_data[k*DW +: DW] = $urandom;
      in_valid  = r_iv;
      out_ready = r_ordy;
      flush     = r_fl;
      in_data   = r_data;
      exp_data  = (q.size() > 0) ? q[0] : '0;
      chk("soak_out_valid", W'(out_valid), W'(q.size() > 0));
      chk("soak_in_ready", W'(in_ready), W'(q.size() < 2));
      chk("soak_out_data", out_data, exp_data);
      chk("soak_stall", W'(stall_cnt), W'(m_stall));
      chk("soak_bubble", W'(bubble_cnt), W'(m_bub));
      if ((q.size() > 0) && !r_ordy && (m_stall != 65535)) m_stall++;
      if ((q.size() == 0) && r_ordy && (m_bub != 65535)) m_bub++;
      if (r_fl) begin
        q.delete();
      end else begin
        logic acc;
        acc = r_iv && (q.size() < 2);
        if ((q.size() > 0) && r_ordy) void'(q.pop_front());
        if (acc) q.push_back(r_data);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
